// File: rtl/adc_scan_pkg.sv
// Shared definitions for the ADC scan controller: FSM encoding, control-byte
// fields, SCLK milestones and the channel-to-address mapping.
package adc_scan_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_GAP,
    ST_FINISH
  } scan_state_e;

  // Control-byte fields: START, unipolar, single-ended, external clock.
  localparam logic       CTRL_START = 1'b1;
  localparam logic       CTRL_UNI   = 1'b1;
  localparam logic       CTRL_SGL   = 1'b1;
  localparam logic [1:0] CTRL_PD    = 2'b11;

  // 1-based SCLK milestones within one 24-clock transaction.
  localparam logic [4:0] SCLK_CTRL_BITS = 5'd8;
  localparam logic [4:0] SCLK_RX_FIRST  = 5'd10;
  localparam logic [4:0] SCLK_RX_LAST   = 5'd21;
  localparam logic [4:0] SCLK_TOTAL     = 5'd24;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } chan_pick_t;

  // The ADC's address pins are wired in a rotated order relative to idx[2:0].
  function automatic logic [2:0] chan_addr(input logic [2:0] c);
    return {c[0], c[2], c[1]};
  endfunction

  function automatic logic [7:0] ctrl_byte(input logic [3:0] idx);
    return {CTRL_START, chan_addr(idx[2:0]), CTRL_UNI, CTRL_SGL, CTRL_PD};
  endfunction

  // Lowest set bit of the mask; found=0 when the mask is empty.
  function automatic chan_pick_t lowest_chan(input logic [15:0] m);
    chan_pick_t p;
    p.found = 1'b0;
    p.idx   = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) begin
        p.found = 1'b1;
        p.idx   = 4'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/adc_spi_xfer.sv
// One 24-SCLK ADC transaction: shifts the control byte out on MOSI, captures
// the 12-bit conversion from MISO and hands it back with a go/ack handshake.
module adc_spi_xfer
  import adc_scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        go_i,
  input  logic [7:0]  ctrl_i,
  input  logic        miso_i,
  output logic        ack_o,
  output logic        res_vld_o,
  output logic [11:0] result_o,
  output logic        sclk_o,
  output logic        mosi_o
);

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  logic        active_q, active_d;
  logic [7:0]  hcnt_q, hcnt_d;
  logic        sclk_q, sclk_d;
  logic        mosi_q, mosi_d;
  logic [7:0]  sh_q, sh_d;
  logic [4:0]  nrise_q, nrise_d;
  logic [4:0]  nfall_q, nfall_d;
  logic [11:0] rx_q, rx_d;
  logic        res_vld_q, res_vld_d;

  logic       tick, rise, fall;
  logic [4:0] rise_num, fall_num;

  assign tick     = active_q && (hcnt_q == HALF_LAST);
  assign rise     = tick && !sclk_q;
  assign fall     = tick && sclk_q;
  assign rise_num = nrise_q + 5'd1;
  assign fall_num = nfall_q + 5'd1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    active_d  = active_q;
    hcnt_d    = hcnt_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    sh_d      = sh_q;
    nrise_d   = nrise_q;
    nfall_d   = nfall_q;
    rx_d      = rx_q;
    res_vld_d = 1'b0;
    if (!active_q) begin
      if (go_i) begin
        // MSB goes out immediately so it is settled before the first rise.
        active_d = 1'b1;
        hcnt_d   = '0;
        sclk_d   = 1'b0;
        mosi_d   = ctrl_i[7];
        sh_d     = {ctrl_i[6:0], 1'b0};
        nrise_d  = '0;
        nfall_d  = '0;
      end
    end else begin
      hcnt_d = tick ? 8'd0 : hcnt_q + 8'd1;
      if (rise) begin
        sclk_d  = 1'b1;
        nrise_d = rise_num;
        if (rise_num >= SCLK_RX_FIRST && rise_num <= SCLK_RX_LAST) begin
          rx_d = {rx_q[10:0], miso_i};
        end
        res_vld_d = (rise_num == SCLK_RX_LAST);
      end
      if (fall) begin
        sclk_d  = 1'b0;
        nfall_d = fall_num;
        mosi_d  = (fall_num < SCLK_CTRL_BITS) ? sh_q[7] : 1'b0;
        sh_d    = {sh_q[6:0], 1'b0};
        if (fall_num == SCLK_TOTAL) begin
          active_d = 1'b0;
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= 1'b0;
      hcnt_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      sh_q      <= '0;
      nrise_q   <= '0;
      nfall_q   <= '0;
      rx_q      <= '0;
      res_vld_q <= 1'b0;
    end else begin
      active_q  <= active_d;
      hcnt_q    <= hcnt_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      sh_q      <= sh_d;
      nrise_q   <= nrise_d;
      nfall_q   <= nfall_d;
      rx_q      <= rx_d;
      res_vld_q <= res_vld_d;
    end
  end

  assign ack_o     = fall && (fall_num == SCLK_TOTAL);
  assign res_vld_o = res_vld_q;
  assign result_o  = rx_q;
  assign sclk_o    = sclk_q;
  assign mosi_o    = mosi_q;

endmodule

// File: rtl/adc_scan_ctrl.sv
// Scans the channels enabled in chan_mask through a bank-switched serial ADC
// and keeps the latest 12-bit result per channel. Define
// ADC_SCAN_CONTINUOUS_EN to add the `stop` input and repeat scans until stopped.
module adc_scan_ctrl
  import adc_scan_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        start,
  input  logic [15:0] chan_mask,
`ifdef ADC_SCAN_CONTINUOUS_EN
  input  logic        stop,
`endif
  output logic        busy,
  output logic        done,
  input  logic [3:0]  rd_addr,
  output logic [11:0] rd_data,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        nCS,
  output logic        SEL
);

  localparam logic [8:0] HALF_LAST = 9'(CLK_DIV - 1);
  localparam logic [8:0] FULL_LAST = 9'(2 * CLK_DIV - 1);

  scan_state_e state_q, state_d;
  logic [15:0] mask_q, mask_d;
  logic [3:0]  idx_q, idx_d;
  logic [8:0]  cnt_q, cnt_d;
  logic        ncs_q, ncs_d;
  logic        sel_q, sel_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [11:0] res_q [16];

  logic        xfer_go, xfer_ack, xfer_vld;
  logic [11:0] xfer_result;
  chan_pick_t  first_pick, restart_pick, next_pick;
  logic [15:0] above_mask;

  assign first_pick   = lowest_chan(chan_mask);
  assign restart_pick = lowest_chan(mask_q);
  // Only channels strictly above the current one; the search never wraps.
  assign above_mask   = 16'hFFFF << ({1'b0, idx_q} + 5'd1);
  assign next_pick    = lowest_chan(mask_q & above_mask);

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    ncs_d   = ncs_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    xfer_go = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mask_d = chan_mask;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (first_pick.found) begin
            state_d = ST_SETUP;
            idx_d   = first_pick.idx;
            sel_d   = ~first_pick.idx[3];
          end else begin
            state_d = ST_FINISH;
          end
        end
      end
      ST_SETUP: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == HALF_LAST) begin
          ncs_d = 1'b0;
        end
        if (cnt_q == FULL_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          xfer_go = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (xfer_ack) begin
          ncs_d   = 1'b1;
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        cnt_d = cnt_q + 9'd1;
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (next_pick.found) begin
            state_d = ST_SETUP;
            idx_d   = next_pick.idx;
            sel_d   = ~next_pick.idx[3];
          end else begin
            state_d = ST_FINISH;
            sel_d   = 1'b1;
          end
        end
      end
      ST_FINISH: begin
        done_d = 1'b1;
`ifdef ADC_SCAN_CONTINUOUS_EN
        if (!stop) begin
          cnt_d = '0;
          if (restart_pick.found) begin
            state_d = ST_SETUP;
            idx_d   = restart_pick.idx;
            sel_d   = ~restart_pick.idx[3];
          end
        end else begin
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
`else
        busy_d  = 1'b0;
        state_d = ST_IDLE;
`endif
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        ncs_d   = 1'b1;
        sel_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      ncs_q   <= 1'b1;
      sel_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ncs_q   <= ncs_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // NOTE: the result file is cleared by reset because reads of never-scanned
  // channels must return 0; a memory without reset would power up undefined.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < 16; i++) begin
        res_q[i] <= '0;
      end
    end else if (xfer_vld && state_q == ST_SHIFT) begin
      res_q[idx_q] <= xfer_result;
    end
  end

  adc_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .clk       (CLK),
    .rst_n     (nRST),
    .go_i      (xfer_go),
    .ctrl_i    (ctrl_byte(idx_q)),
    .miso_i    (MISO),
    .ack_o     (xfer_ack),
    .res_vld_o (xfer_vld),
    .result_o  (xfer_result),
    .sclk_o    (SCLK),
    .mosi_o    (MOSI)
  );

  assign busy    = busy_q;
  assign done    = done_q;
  assign nCS     = ncs_q;
  assign SEL     = sel_q;
  assign rd_data = res_q[rd_addr];

endmodule
